// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle control sequencer for a small MIPS subset.
// Accepts one instruction per handshake, decodes opcode/funct and steps it
// through DECODE, EXEC and the memory/write-back/branch states, driving the
// ALU operation select and the datapath strobes around it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr, instr_valid       instruction word and its valid flag
//   instr_ready              high only while idle
//   zero                     ALU zero flag (from the registered ALU result)
//   ALUOp                    ALU select: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 1111 NOP
//   ALUSrc, imm_zext, RegDst operand/immediate/destination selects
//   RegWrite, MemRead, MemWrite, MemtoReg, pc_src   datapath strobes
//   done, illegal            end-of-instruction pulse, unsupported-encoding pulse
module alu_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        zero,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        imm_zext,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        pc_src,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0011;
    localparam logic [3:0] ALUOP_NOP = 4'b1111;

    typedef enum logic [2:0] {
        StIdle, StDecode, StExec, StWb, StMemRd, StMemWb, StMemWr, StBr
    } state_e;

    typedef enum logic [1:0] {KindAlu, KindLoad, KindStore, KindBranch} kind_e;

    state_e     state_q, state_d;
    // Only opcode and funct are kept; the rest of the word is never needed.
    logic [5:0] opcode_q;
    logic [5:0] funct_q;

    logic       dec_legal;
    logic [3:0] dec_op;
    logic       dec_src;
    logic       dec_zext;
    logic       dec_regdst;
    kind_e      dec_kind;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && instr_valid) begin
                opcode_q <= instr[31:26];
                funct_q  <= instr[5:0];
            end
        end
    end

    // Decode works from the captured fields only, so it is stable for the
    // whole instruction and the ALU controls stay constant from EXEC onward.
    always_comb begin
        dec_legal  = 1'b0;
        dec_op     = ALUOP_NOP;
        dec_src    = 1'b0;
        dec_zext   = 1'b0;
        dec_regdst = 1'b0;
        dec_kind   = KindAlu;
        case (opcode_q)
            6'h00: begin
                case (funct_q)
                    6'h20: begin dec_legal = 1'b1; dec_op = ALUOP_ADD; end
                    6'h22: begin dec_legal = 1'b1; dec_op = ALUOP_SUB; end
                    6'h24: begin dec_legal = 1'b1; dec_op = ALUOP_AND; end
                    6'h25: begin dec_legal = 1'b1; dec_op = ALUOP_OR;  end
                    default: ;
                endcase
                dec_regdst = dec_legal;
            end
            6'h08: begin dec_legal = 1'b1; dec_op = ALUOP_ADD; dec_src = 1'b1; end
            6'h0C: begin
                dec_legal = 1'b1; dec_op = ALUOP_AND; dec_src = 1'b1; dec_zext = 1'b1;
            end
            6'h0D: begin
                dec_legal = 1'b1; dec_op = ALUOP_OR; dec_src = 1'b1; dec_zext = 1'b1;
            end
            6'h23: begin
                dec_legal = 1'b1; dec_op = ALUOP_ADD; dec_src = 1'b1; dec_kind = KindLoad;
            end
            6'h2B: begin
                dec_legal = 1'b1; dec_op = ALUOP_ADD; dec_src = 1'b1; dec_kind = KindStore;
            end
            6'h04: begin dec_legal = 1'b1; dec_op = ALUOP_SUB; dec_kind = KindBranch; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        ALUOp       = ALUOP_NOP;
        ALUSrc      = 1'b0;
        imm_zext    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        pc_src      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;

        // ALU controls are held from EXEC through the final cycle.
        if (state_q != StIdle && state_q != StDecode) begin
            ALUOp    = dec_op;
            ALUSrc   = dec_src;
            imm_zext = dec_zext;
            RegDst   = dec_regdst;
        end

        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StDecode;
            end
            StDecode: begin
                if (dec_legal) begin
                    state_d = StExec;
                end else begin
                    done    = 1'b1;
                    illegal = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                unique case (dec_kind)
                    KindAlu:    state_d = StWb;
                    KindLoad:   state_d = StMemRd;
                    KindStore:  state_d = StMemWr;
                    KindBranch: state_d = StBr;
                endcase
            end
            StWb: begin
                RegWrite = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            StMemRd: begin
                MemRead = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            StBr: begin
                // zero reflects the ALU result registered at the end of EXEC.
                pc_src  = zero;
                done    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed testbench for alu_control_fsm. Inputs change and outputs are
// sampled 1 time unit after each rising edge; "cycle N" is the clock period
// following the Nth edge after the handshake cycle.
module tb_alu_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zero;
    logic [3:0]  ALUOp;
    logic        ALUSrc, imm_zext, RegDst;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, pc_src, done, illegal;

    int total = 0;
    int bad   = 0;

    alu_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .zero        (zero),
        .ALUOp       (ALUOp),
        .ALUSrc      (ALUSrc),
        .imm_zext    (imm_zext),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .pc_src      (pc_src),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Output vector layout:
    // {ready, ALUOp[3:0], ALUSrc, imm_zext, RegDst,
    //  RegWrite, MemRead, MemWrite, MemtoReg, pc_src, done, illegal}
    logic [14:0] obs;
    assign obs = {instr_ready, ALUOp, ALUSrc, imm_zext, RegDst,
                  RegWrite, MemRead, MemWrite, MemtoReg, pc_src, done, illegal};

    function automatic logic [14:0] mk(input logic rdy, input logic [3:0] op,
                                       input logic src, input logic zx, input logic rd,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic m2r, input logic pc, input logic dn,
                                       input logic il);
        return {rdy, op, src, zx, rd, rw, mr, mw, m2r, pc, dn, il};
    endfunction

    localparam logic [14:0] IDLE_V = {1'b1, 4'b1111, 10'b0};
    localparam logic [14:0] BUSY_V = {1'b0, 4'b1111, 10'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; zero = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_idle", IDLE_V);

        // add $3,$1,$2
        accept(32'h0022_1820);
        chk("add_c1", BUSY_V);
        step(); chk("add_c2", mk(0, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("add_c3", mk(0, 4'b0010, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        step(); chk("add_c4", IDLE_V);

        // lw $2,4($1)
        accept(32'h8C22_0004);
        step(); chk("lw_c2", mk(0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("lw_c3", mk(0, 4'b0010, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        step(); chk("lw_c4", mk(0, 4'b0010, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0));
        step(); chk("lw_c5", IDLE_V);

        // beq, taken
        accept(32'h1022_0003);
        step(); chk("beq1_c2", mk(0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        zero = 1'b1;
        step(); chk("beq1_c3", mk(0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        step(); chk("beq1_c4", IDLE_V);

        // beq, not taken
        accept(32'h1022_0003);
        step(); zero = 1'b0;
        step(); chk("beq0_c3", mk(0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(); chk("beq0_c4", IDLE_V);

        // ori
        accept(32'h3422_0FFF);
        step(); chk("ori_c2", mk(0, 4'b0001, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("ori_c3", mk(0, 4'b0001, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        step();

        // andi
        accept(32'h3022_000F);
        step(); chk("andi_c2", mk(0, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(); step();

        // addi: sign-extended immediate
        accept(32'h2022_FFFF);
        step(); step(); chk("addi_c3", mk(0, 4'b0010, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        step();

        // sw
        accept(32'hAC22_0004);
        step(); step(); chk("sw_c3", mk(0, 4'b0010, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        step(); chk("sw_c4", IDLE_V);

        // R-type or
        accept(32'h0022_1825);
        step(); chk("or_c2", mk(0, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(); step();

        // illegal funct 0x2A (slt)
        accept(32'h0022_182A);
        chk("ilf_c1", mk(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(); chk("ilf_c2", IDLE_V);

        // illegal opcode (lui)
        accept(32'h3C22_0001);
        chk("ilo_c1", mk(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(); chk("ilo_c2", IDLE_V);

        // sub with instr_valid held high and instr changed while busy
        instr = 32'h0022_1822; instr_valid = 1'b1;
        step();
        instr = 32'h8C22_0004;
        step(); chk("busy_c2", mk(0, 4'b0011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("busy_c3", mk(0, 4'b0011, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        instr_valid = 1'b0;
        step(); chk("busy_c4", IDLE_V);
        step(); chk("busy_c5", IDLE_V);

        // reset in MEM_RD of lw aborts without done
        accept(32'h8C22_0004);
        step(); step();
        chk("rstmid_c3", mk(0, 4'b0010, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_c4", IDLE_V);
        step(); chk("rstmid_c5", IDLE_V);

        // handshake coinciding with reset is dropped
        rst = 1'b1; instr = 32'h0022_1820; instr_valid = 1'b1;
        step();
        rst = 1'b0; instr_valid = 1'b0;
        chk("rsths_c1", IDLE_V);
        step(); chk("rsths_c2", IDLE_V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
